// File: rtl/eth_loopback_line_lb_ready_adapter.sv
`default_nettype none
// ============================================================================
// Module  : eth_loopback_line_lb_ready_adapter
// Brief   : Non-backpressured source to ready/valid sink adapter; show-ahead
//           FIFO absorbs stalls, beats arriving while full are dropped/counted.
// Revision: 1.0 - initial release
// ============================================================================
module eth_loopback_line_lb_ready_adapter #(
  parameter int DATA_W    = 72,
  parameter int ADDR_W    = 3,
  parameter int AFULL_THR = 6,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W:0]   fill_level,
  output logic              almost_full,
  output logic              overflow,
  input  logic              clear_overflow,
  output logic [CNT_W-1:0]  drop_count
);

  localparam int              DEPTH     = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] PTR_ONE   = 1;
  localparam logic [ADDR_W:0] AFULL_LVL = AFULL_THR[ADDR_W:0];
  localparam logic [CNT_W-1:0] CNT_ONE  = 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]   rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   fill_q, fill_d;
  logic              almost_full_q, almost_full_d;
  logic              overflow_q, overflow_d;
  logic [CNT_W-1:0]  drop_count_q, drop_count_d;

  logic empty, full, rd_en, wr_en, drop;

  always_comb begin
    empty = (wr_ptr_q == rd_ptr_q);
    full  = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
            (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);
    rd_en = ~empty & out_ready;
    // A read in the same cycle frees the slot, so a full FIFO still accepts.
    wr_en = in_valid & (~full | rd_en);
    drop  = in_valid & full & ~rd_en;

    wr_ptr_d = wr_en ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = rd_en ? rd_ptr_q + PTR_ONE : rd_ptr_q;

    fill_d = fill_q;
    case ({wr_en, rd_en})
      2'b10:   fill_d = fill_q + PTR_ONE;
      2'b01:   fill_d = fill_q - PTR_ONE;
      default: fill_d = fill_q;
    endcase
    almost_full_d = (fill_d >= AFULL_LVL);

    overflow_d   = overflow_q;
    drop_count_d = drop_count_q;
    if (clear_overflow) begin
      overflow_d   = 1'b0;
      drop_count_d = '0;
    end else if (drop) begin
      overflow_d = 1'b1;
      if (drop_count_q != '1) begin
        drop_count_d = drop_count_q + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      fill_q        <= '0;
      almost_full_q <= 1'b0;
      overflow_q    <= 1'b0;
      drop_count_q  <= '0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      fill_q        <= fill_d;
      almost_full_q <= almost_full_d;
      overflow_q    <= overflow_d;
      drop_count_q  <= drop_count_d;
    end
  end

  // Storage is not reset; pointer reset alone makes its contents unreachable.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q[ADDR_W-1:0]] <= in_data;
    end
  end

  assign out_valid   = ~empty;
  assign out_data    = mem_q[rd_ptr_q[ADDR_W-1:0]];
  assign fill_level  = fill_q;
  assign almost_full = almost_full_q;
  assign overflow    = overflow_q;
  assign drop_count  = drop_count_q;

endmodule
`default_nettype wire

// File: tb/tb_eth_loopback_line_lb_ready_adapter.sv
`default_nettype none
// ============================================================================
// Module  : tb_eth_loopback_line_lb_ready_adapter
// Brief   : Directed bench with a queue-based reference model of the adapter.
// Revision: 1.0 - initial release
// ============================================================================
module tb_eth_loopback_line_lb_ready_adapter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [71:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [71:0] out_data;
  logic [3:0]  fill_level;
  logic        almost_full;
  logic        overflow;
  logic        clear_overflow = 1'b0;
  logic [15:0] drop_count;

  int errors = 0;
  int checks = 0;

  eth_loopback_line_lb_ready_adapter dut (
    .clk            (clk),
    .reset          (reset),
    .in_valid       (in_valid),
    .in_data        (in_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .fill_level     (fill_level),
    .almost_full    (almost_full),
    .overflow       (overflow),
    .clear_overflow (clear_overflow),
    .drop_count     (drop_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: FIFO contents as a queue, plus sticky flag and counter.
  logic [71:0] m_q[$];
  bit          m_ovf = 1'b0;
  int          m_drops = 0;
  bit          m_init = 1'b0;

  always @(posedge clk) begin
    bit rd;
    if (reset) begin
      m_q.delete();
      m_ovf   = 1'b0;
      m_drops = 0;
      m_init  = 1'b1;
    end else if (m_init) begin
      rd = (m_q.size() > 0) && out_ready;
      if (clear_overflow) begin
        m_ovf   = 1'b0;
        m_drops = 0;
      end
      if (rd) void'(m_q.pop_front());
      if (in_valid) begin
        if (m_q.size() < 8) m_q.push_back(in_data);
        else if (!clear_overflow) begin
          m_ovf = 1'b1;
          if (m_drops < 65535) m_drops++;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_init) begin
      check("m_valid", {71'b0, out_valid}, {71'b0, m_q.size() > 0});
      if (m_q.size() > 0) check("m_data", out_data, m_q[0]);
      check("m_fill", {68'b0, fill_level}, 72'(m_q.size()));
      check("m_afull", {71'b0, almost_full}, {71'b0, m_q.size() >= 6});
      check("m_ovf", {71'b0, overflow}, {71'b0, m_ovf});
      check("m_drops", {56'b0, drop_count}, 72'(m_drops));
    end
  end

  task automatic step(input logic rst, input logic iv, input logic [71:0] d,
                      input logic ordy, input logic clr);
    reset          = rst;
    in_valid       = iv;
    in_data        = d;
    out_ready      = ordy;
    clear_overflow = clr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    step(1, 0, '0, 0, 0);
    step(1, 0, '0, 0, 0);
    check("rst_valid", {71'b0, out_valid}, 72'd0);
    check("rst_fill", {68'b0, fill_level}, 72'd0);
    check("rst_afull", {71'b0, almost_full}, 72'd0);
    check("rst_ovf", {71'b0, overflow}, 72'd0);
    check("rst_drops", {56'b0, drop_count}, 72'd0);

    // T1 passthrough: each beat visible right after the edge that wrote it
    for (int i = 0; i < 20; i++) begin
      step(0, 1, 72'(100 + i), 1, 0);
      check("t1_valid", {71'b0, out_valid}, 72'd1);
      check("t1_data", out_data, 72'(100 + i));
      check("t1_fill_le1", {71'b0, fill_level <= 4'd1}, 72'd1);
    end
    step(0, 0, '0, 1, 0);
    check("t1_empty_fill", {68'b0, fill_level}, 72'd0);
    check("t1_ovf", {71'b0, overflow}, 72'd0);

    // T2 stall/fill
    for (int i = 0; i < 8; i++) begin
      step(0, 1, 72'(200 + i), 0, 0);
      check("t2_fill", {68'b0, fill_level}, 72'(i + 1));
      check("t2_afull", {71'b0, almost_full}, {71'b0, i >= 5});
      check("t2_head", out_data, 72'd200);
    end

    // T3 overflow then ordered drain
    for (int i = 0; i < 3; i++) step(0, 1, 72'(300 + i), 0, 0);
    check("t3_ovf", {71'b0, overflow}, 72'd1);
    check("t3_drops", {56'b0, drop_count}, 72'd3);
    check("t3_fill", {68'b0, fill_level}, 72'd8);
    for (int i = 0; i < 8; i++) begin
      check("t3_drain", out_data, 72'(200 + i));
      step(0, 0, '0, 1, 0);
    end
    check("t3_empty", {71'b0, out_valid}, 72'd0);
    check("t3_ovf_sticky", {71'b0, overflow}, 72'd1);

    // T4 full with simultaneous read/write
    step(0, 0, '0, 0, 1);
    check("t4_clr", {56'b0, drop_count}, 72'd0);
    for (int i = 0; i < 8; i++) step(0, 1, 72'(400 + i), 0, 0);
    for (int i = 0; i < 10; i++) begin
      check("t4_head", out_data, (i < 8) ? 72'(400 + i) : 72'(500 + i - 8));
      step(0, 1, 72'(500 + i), 1, 0);
      check("t4_fill", {68'b0, fill_level}, 72'd8);
      check("t4_drops", {56'b0, drop_count}, 72'd0);
    end

    // T5 reset mid-stream
    step(1, 0, '0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 1, 72'(600 + i), 0, 0);
    check("t5_fill5", {68'b0, fill_level}, 72'd5);
    step(1, 0, '0, 0, 0);
    check("t5_valid", {71'b0, out_valid}, 72'd0);
    check("t5_fill", {68'b0, fill_level}, 72'd0);
    check("t5_drops", {56'b0, drop_count}, 72'd0);
    step(0, 1, 72'd700, 0, 0);
    check("t5_new_valid", {71'b0, out_valid}, 72'd1);
    check("t5_new_data", out_data, 72'd700);

    // T6 clear wins over a same-cycle drop
    for (int i = 1; i < 8; i++) step(0, 1, 72'(700 + i), 0, 0);
    step(0, 1, 72'd998, 0, 0);
    check("t6_pre_ovf", {71'b0, overflow}, 72'd1);
    check("t6_pre_drops", {56'b0, drop_count}, 72'd1);
    step(0, 1, 72'd999, 0, 1);
    check("t6_ovf", {71'b0, overflow}, 72'd0);
    check("t6_drops", {56'b0, drop_count}, 72'd0);
    check("t6_fill", {68'b0, fill_level}, 72'd8);
    for (int i = 0; i < 8; i++) begin
      check("t6_drain", out_data, 72'(700 + i));
      step(0, 0, '0, 1, 0);
    end
    step(0, 0, '0, 1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
